// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchronised rxd, 16x-oversampled deframing, valid/ready byte output.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data and stop bits (8E1).
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic [3:0]           tcnt;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic parity_pend;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      // NOTE: non-blocking so rxd_s takes last cycle's rxd_m, giving two real flop stages.
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_pend  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: pulse defaults first; a later assignment in this block overrides them this cycle.
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (rx_tick) begin
        unique case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              state <= S_START;
              tcnt  <= '0;
            end
          end
          S_START: begin
            if (tcnt == 4'd7) begin
              tcnt <= '0;
              if (!rxd_s) begin
                state <= S_DATA;
                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                parity_pend <= 1'b0;
`endif
              end else begin
                state <= S_IDLE;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          S_DATA: begin
            if (tcnt == 4'd15) begin
              shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + 4'd1;
              tcnt  <= '0;
              if (bcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          S_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (tcnt == 4'd15) begin
              parity_pend <= (rxd_s != ^shreg);
              tcnt        <= '0;
              state       <= S_STOP;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
`else
            state <= S_IDLE;
`endif
          end
          S_STOP: begin
            if (tcnt == 4'd15) begin
              tcnt <= '0;
              if (rxd_s) begin
                // A delivery that coincides with a handshake replaces the byte without overrun.
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= parity_pend;
`endif
                state <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          S_BREAK: begin
            if (rxd_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
